// File: rtl/wb_regfile_stage.sv
// Writeback stage: latches the MM result, commits it to the register file one
// edge later, and serves two combinational read ports with pending-commit bypass.
module wb_regfile_stage #(
    parameter int DW       = 16,
    parameter int AW       = 4,
    parameter int ZERO_REG = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] MMOUT,
    input  logic [AW-1:0] RD,
    input  logic          RW,
    input  logic          VALID_IN,
    input  logic          STALL,
    input  logic          FLUSH,
    input  logic [AW-1:0] RA1,
    input  logic [AW-1:0] RA2,
    output logic [DW-1:0] RD1,
    output logic [DW-1:0] RD2,
    output logic          WB_VALID,
    output logic          WB_WE,
    output logic [AW-1:0] WB_ADDR,
    output logic [DW-1:0] WB_DATA,
    output logic [15:0]   RETIRED
);

    localparam int NREG = 1 << AW;
    localparam bit ZR   = (ZERO_REG != 0);

    logic          wb_valid_q, wb_valid_d;
    logic          wb_we_q,    wb_we_d;
    logic [AW-1:0] wb_addr_q,  wb_addr_d;
    logic [DW-1:0] wb_data_q,  wb_data_d;
    logic [15:0]   retired_q,  retired_d;
    logic [DW-1:0] regs_q [NREG];
    logic [DW-1:0] regs_d [NREG];

    // Handshake: VALID_IN qualifies the MM contents; STALL is an inverted ready.
    // While STALL=1 MM keeps its instruction and this stage inserts a bubble; the
    // instruction is taken on the first edge with STALL=0. FLUSH kills it outright.
    always_comb begin
        wb_valid_d = wb_valid_q;
        wb_we_d    = wb_we_q;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;
        if (FLUSH || STALL) begin
            wb_valid_d = 1'b0;
            wb_we_d    = 1'b0;
        end else begin
            wb_valid_d = VALID_IN;
            wb_we_d    = VALID_IN & RW;
            wb_addr_d  = RD;
            wb_data_d  = MMOUT;
        end
    end

    // Commit uses the stage contents as they stood before this edge.
    always_comb begin
        regs_d = regs_q;
        if (wb_we_q && !(ZR && wb_addr_q == '0)) begin
            regs_d[wb_addr_q] = wb_data_q;
        end
        retired_d = retired_q + (wb_valid_q ? 16'd1 : 16'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid_q <= 1'b0;
            wb_we_q    <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            retired_q  <= '0;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            wb_valid_q <= wb_valid_d;
            wb_we_q    <= wb_we_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
            retired_q  <= retired_d;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // R0 check comes last so it overrides the bypass when ZERO_REG is set.
    always_comb begin
        RD1 = regs_q[RA1];
        if (wb_we_q && RA1 == wb_addr_q) RD1 = wb_data_q;
        if (ZR && RA1 == '0) RD1 = '0;
    end

    always_comb begin
        RD2 = regs_q[RA2];
        if (wb_we_q && RA2 == wb_addr_q) RD2 = wb_data_q;
        if (ZR && RA2 == '0) RD2 = '0;
    end

    assign WB_VALID = wb_valid_q;
    assign WB_WE    = wb_we_q;
    assign WB_ADDR  = wb_addr_q;
    assign WB_DATA  = wb_data_q;
    assign RETIRED  = retired_q;

endmodule
